alu_sweep_sequencer: RTL
========================

# alu_sweep_sequencer

Self-checking sequencer that drives the SM83 ALU as an adder through a programmable sweep of operand pairs. Each pair is presented on DV/alu, the sum select x[3] (s3_alu_sum) is asserted, and the sequencer waits for the ALU's synchronous evaluation window (ADR_CLK_P high). It then captures Res, compares it with the expected modulo-256 sum and keeps error statistics. It sits between the External_CLK phase outputs and the ALU operand and select inputs in unit-test and bring-up benches, replacing the static operand registers and fixed mock decoder line.

## Interface
Parameters:
- PAIRS, 256, number of operand pairs per sweep (1..65536)
- B_STEP, 1, increment applied to operand B per pair (mod 256)
- SETTLE_CYCLES, 2, CLK cycles after ADR_CLK_P rise before Res is sampled (>=1)
- TIMEOUT, 64, CLK cycles allowed waiting for ADR_CLK_P rise per pair

Ports:
- CLK  in  1  system clock, all state on posedge
- RESET  in  1  asynchronous, active-high reset
- Start  in  1  sweep request, sampled only in IDLE or DONE
- ADR_CLK_P  in  1  ALU evaluation phase from External_CLK
- Res  in  8  ALU result
- AllZeros  in  1  ALU zero detect
- DV  out  8  operand A to ALU
- alu  out  8  operand B to ALU
- AluSum  out  1  drives decoder x[3]; all other x/w/d lines are held 0 by the bench
- Busy  out  1  sweep in progress
- Done  out  1  sweep finished, level
- Timeout  out  1  sweep aborted on missing ADR_CLK_P
- PairCount  out  17  pairs checked
- ErrCount  out  16  mismatches, saturating at 0xFFFF
- FirstErrA, FirstErrB  out  8 each  operands of first mismatch

## Operation
- States: IDLE, DRIVE, WAIT_EDGE, SETTLE, CHECK, DONE.
- IDLE/DONE: Start=1 clears PairCount, ErrCount, FirstErr*, Timeout and Done, sets A=0 and B=0, and moves to DRIVE. Start is ignored in any other state.
- DRIVE: DV=A, alu=B, AluSum=1, clears the timeout counter, then WAIT_EDGE. Operands stay stable from DRIVE through CHECK.
- WAIT_EDGE: waits for a rising ADR_CLK_P, detected as the registered previous value 0 and the current value 1. The rise moves the FSM to SETTLE. If TIMEOUT cycles elapse first, Timeout=1 and the FSM goes to DONE.
- SETTLE: counts SETTLE_CYCLES. If ADR_CLK_P falls during the count, the FSM returns to WAIT_EDGE. When the count completes, Res is sampled and the FSM moves to CHECK.
- CHECK: mismatch when Res != (A+B)[7:0]. On a mismatch with ErrCount==0, the current A and B are latched into FirstErr*. ErrCount increments unless saturated, and PairCount increments.
  - If PairCount then reaches PAIRS, the FSM goes to DONE.
  - Otherwise A becomes A+1 (mod 256), B becomes B+B_STEP (mod 256), and the FSM goes to DRIVE.
- DONE: Done=1 and AluSum=0. DV and alu hold their last values.
- Arithmetic: expected sum is 9-bit and truncated to 8 bits. Operand wrap at 255 -> 0 is legal.

## Timing
- Reset values: DV=0, alu=0, AluSum=0, Busy=0, Done=0, Timeout=0, PairCount=0, ErrCount=0, FirstErrA=0, FirstErrB=0, state IDLE.
- RESET mid-sweep aborts immediately to these values. The first Start after reset release starts a fresh sweep.
- Busy=1 in DRIVE through CHECK. Done rises one cycle after the final CHECK.
- Minimum per-pair latency is 1 (DRIVE) + 1 (edge detect) + SETTLE_CYCLES + 1 (CHECK).
- Start held high in DONE restarts the sweep; this is legal.

## Configuration
- ALU_SWEEP_FLAGS_CHECK_EN defined: CHECK also flags a mismatch when AllZeros != ((A+B)[7:0]==0). A pair counts as at most one error.
- Undefined: AllZeros is ignored and there is no flag logic.

## Structure
- Shared include alu_sweep_defs.vh: state encodings and the expected-sum width constant.
- One sub-module, alu_sweep_phase_det, holds the ADR_CLK_P edge detector plus the settle and timeout counters. It outputs rise, sample and timeout pulses.

## Test plan
- Reset asserted, then released with no Start -> all outputs at reset values, state IDLE.
- Start with PAIRS=256, B_STEP=1 and a behavioural ALU (Res=DV+alu) -> Done=1, PairCount=256, ErrCount=0, last DV=0xFF, alu=0xFF.
- Model returns Res^0x01 when DV==0x10 -> ErrCount=1, FirstErrA=0x10, FirstErrB=0x10.
- ADR_CLK_P stuck 0 with TIMEOUT=64 -> Timeout=1 and Done=1 64 cycles after DRIVE, PairCount=0.
- RESET pulsed while PairCount=100 -> Busy=0, PairCount=0. A subsequent Start completes with PairCount=256.
- Model forces AllZeros=0 with A=0x80, B=0x80 (B_STEP=1, PAIRS=256) -> ErrCount=1 with ALU_SWEEP_FLAGS_CHECK_EN, ErrCount=0 without.

Source files
------------

// File: rtl/alu_sweep_sequencer_pkg.sv
// Shared definitions for the ALU adder sweep sequencer: FSM state
// encoding, expected-sum width and the reference sum helper.
package alu_sweep_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRIVE     = 3'd1,
    ST_WAIT_EDGE = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Full-width adder result; only the low byte is compared against Res.
  localparam int unsigned SUM_W = 9;

  function automatic logic [7:0] expected_sum(input logic [7:0] a,
                                               input logic [7:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0];
  endfunction

endpackage

// File: rtl/alu_sweep_phase_det.sv
// ADR_CLK_P phase detector: registered edge detect, settle counter and
// per-pair timeout counter. Produces rise/fall, sample and timeout pulses.
module alu_sweep_phase_det #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic adr_clk_p,
  input  logic clr_timeout,
  input  logic wait_en,
  input  logic settle_en,
  output logic rise,
  output logic fall,
  output logic sample,
  output logic timeout
);

  localparam int unsigned SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic          prev_q;
  logic [SW-1:0] settle_cnt_q;
  logic [TW-1:0] wait_cnt_q;

  assign rise    = ~prev_q & adr_clk_p;
  assign fall    = prev_q & ~adr_clk_p;
  assign sample  = settle_en & ~fall & (settle_cnt_q == SW'(SETTLE_CYCLES - 1));
  assign timeout = wait_en & ~rise & (wait_cnt_q == TW'(TIMEOUT - 1));

  // Previous ADR_CLK_P value for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev_q <= 1'b0;
    else       prev_q <= adr_clk_p;
  end

  // Settle counter runs only while settling; a fall restarts the window.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                  settle_cnt_q <= '0;
    else if (!settle_en || fall) settle_cnt_q <= '0;
    else                        settle_cnt_q <= settle_cnt_q + SW'(1);
  end

  // Timeout counter accumulates waiting cycles for the current pair only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                wait_cnt_q <= '0;
    else if (clr_timeout)     wait_cnt_q <= '0;
    else if (wait_en && !rise) wait_cnt_q <= wait_cnt_q + TW'(1);
  end

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Sweeps operand pairs through the ALU adder path and counts mismatches
// between Res and the modulo-256 sum.
// Optional: ALU_SWEEP_FLAGS_CHECK_EN also checks AllZeros against the sum.
module alu_sweep_sequencer
  import alu_sweep_sequencer_pkg::*;
#(
  parameter int unsigned PAIRS         = 256,
  parameter int unsigned B_STEP        = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic        ADR_CLK_P,
  input  logic [7:0]  Res,
  input  logic        AllZeros,
  output logic [7:0]  DV,
  output logic [7:0]  alu,
  output logic        AluSum,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout,
  output logic [16:0] PairCount,
  output logic [15:0] ErrCount,
  output logic [7:0]  FirstErrA,
  output logic [7:0]  FirstErrB
);

  state_t state_q, state_d;

  logic [7:0]  a_q, b_q, res_q;
  logic [7:0]  fa_q, fb_q;
  logic [16:0] pair_q;
  logic [15:0] err_q;
  logic        tmo_q;
  logic        rise, fall, sample, tmo_pulse;
  logic        busy, last_pair, mismatch;
  logic [7:0]  exp_sum;

  alu_sweep_phase_det #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) u_phase_det (
    .CLK        (CLK),
    .RESET      (RESET),
    .adr_clk_p  (ADR_CLK_P),
    .clr_timeout(state_q == ST_DRIVE),
    .wait_en    (state_q == ST_WAIT_EDGE),
    .settle_en  (state_q == ST_SETTLE),
    .rise       (rise),
    .fall       (fall),
    .sample     (sample),
    .timeout    (tmo_pulse)
  );

  assign exp_sum   = expected_sum(a_q, b_q);
  assign last_pair = (pair_q + 17'd1) == 17'(PAIRS);

`ifdef ALU_SWEEP_FLAGS_CHECK_EN
  logic zero_q;

  // Zero flag captured alongside Res at the end of the settle window.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                 zero_q <= 1'b0;
    else if (state_q == ST_SETTLE && sample)   zero_q <= AllZeros;
  end

  // A pair with both a bad sum and a bad flag still counts once.
  always_comb begin
    mismatch = 1'b0;
    if ((res_q != exp_sum) || (zero_q != (exp_sum == 8'h00))) mismatch = 1'b1;
  end
`else
  logic unused_allzeros;
  assign unused_allzeros = AllZeros;

  // Sum-only comparison.
  always_comb begin
    mismatch = 1'b0;
    if (res_q != exp_sum) mismatch = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (Start) state_d = ST_DRIVE;
      ST_DRIVE: begin
        busy    = 1'b1;
        state_d = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        busy = 1'b1;
        if (rise)           state_d = ST_SETTLE;
        else if (tmo_pulse) state_d = ST_DONE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (fall)        state_d = ST_WAIT_EDGE;
        else if (sample) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        busy    = 1'b1;
        state_d = last_pair ? ST_DONE : ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands, captured result and error statistics.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      pair_q <= '0;
      err_q  <= '0;
      tmo_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            a_q    <= '0;
            b_q    <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
            pair_q <= '0;
            err_q  <= '0;
            tmo_q  <= 1'b0;
          end
        end
        ST_WAIT_EDGE: if (!rise && tmo_pulse) tmo_q <= 1'b1;
        ST_SETTLE:    if (sample) res_q <= Res;
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q == '0) begin
              fa_q <= a_q;
              fb_q <= b_q;
            end
            if (err_q != '1) err_q <= err_q + 16'd1;
          end
          pair_q <= pair_q + 17'd1;
          if (!last_pair) begin
            a_q <= a_q + 8'd1;
            b_q <= b_q + 8'(B_STEP);
          end
        end
        default: ;
      endcase
    end
  end

  assign DV        = a_q;
  assign alu       = b_q;
  assign AluSum    = busy;
  assign Busy      = busy;
  assign Done      = (state_q == ST_DONE);
  assign Timeout   = tmo_q;
  assign PairCount = pair_q;
  assign ErrCount  = err_q;
  assign FirstErrA = fa_q;
  assign FirstErrB = fb_q;

endmodule
